nios_simple_st_width_adapter_32to8: RTL and testbench



---
 rtl/nios_simple_st_pkg.sv | 15 +
 rtl/nios_simple_st_width_adapter_32to8.sv | 78 +++++++
 tb/tb_nios_simple_st_width_adapter_32to8.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_simple_st_pkg.sv
// Shared Avalon-ST constants for the nios_simple streaming datapath.
package nios_simple_st_pkg;

    localparam int ST_SYMBOL_W     = 8;
    localparam int ST_BEAT_SYMBOLS = 4;
    localparam int ST_EMPTY_W      = 2;

    // Bit offset of the LSB of symbol k in a beat; symbol 0 occupies the MSBs.
    function automatic int unsigned sym_lsb(input int unsigned k,
                                            input int unsigned n_sym,
                                            input int unsigned sym_w);
        return (n_sym - 1 - k) * sym_w;
    endfunction

endpackage

// File: rtl/nios_simple_st_width_adapter_32to8.sv
// Avalon-ST 32-to-8 width adapter: serialises each beat MSB symbol first and
// drops the empty trailing symbols of the final beat.
module nios_simple_st_width_adapter_32to8
    import nios_simple_st_pkg::*;
#(
    parameter int SYMBOL_W   = ST_SYMBOL_W,
    parameter int IN_SYMBOLS = ST_BEAT_SYMBOLS,
    parameter int EMPTY_W    = ST_EMPTY_W
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           in_ready,
    input  logic                           in_valid,
    input  logic [SYMBOL_W*IN_SYMBOLS-1:0] in_data,
    input  logic                           in_startofpacket,
    input  logic                           in_endofpacket,
    input  logic [EMPTY_W-1:0]             in_empty,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [SYMBOL_W-1:0]            out_data,
    output logic                           out_startofpacket,
    output logic                           out_endofpacket
);

    localparam int                 DATA_W    = SYMBOL_W * IN_SYMBOLS;
    localparam logic [EMPTY_W-1:0] LAST_FULL = EMPTY_W'(IN_SYMBOLS - 1);

    logic [DATA_W-1:0]  r_data;
    logic               r_sop;
    logic               r_eop;
    logic [EMPTY_W-1:0] r_last_idx;
    logic               r_hold_valid;
    logic [EMPTY_W-1:0] r_idx;

    logic               w_last;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [DATA_W-1:0]  w_shifted;

    assign w_last     = (r_idx == r_last_idx);
    // Accept the next beat in the same cycle the last symbol leaves: no bubble.
    assign in_ready   = !reset && (!r_hold_valid || (out_ready && w_last));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_hold_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_last_idx   <= '0;
            r_hold_valid <= 1'b0;
            r_idx        <= '0;
        end else if (w_in_xfer) begin
            r_data       <= in_data;
            r_sop        <= in_startofpacket;
            r_eop        <= in_endofpacket;
            r_last_idx   <= in_endofpacket ? (LAST_FULL - in_empty) : LAST_FULL;
            r_hold_valid <= 1'b1;
            r_idx        <= '0;
        end else if (w_out_xfer) begin
            if (!w_last) begin
                r_idx <= r_idx + EMPTY_W'(1);
            end else begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_shifted         = r_data >> sym_lsb(32'(r_idx), IN_SYMBOLS, SYMBOL_W);
        out_data          = w_shifted[SYMBOL_W-1:0];
        out_valid         = r_hold_valid;
        out_startofpacket = r_sop && (r_idx == '0);
        out_endofpacket   = r_eop && w_last;
    end

endmodule

// File: tb/tb_nios_simple_st_width_adapter_32to8.sv
// Scoreboard bench for the 32-to-8 width adapter: directed packets plus random traffic.
module tb_nios_simple_st_width_adapter_32to8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [1:0]  in_empty = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;

    nios_simple_st_width_adapter_32to8 #(
        .SYMBOL_W  (8),
        .IN_SYMBOLS(4),
        .EMPTY_W   (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_empty         (in_empty),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
    } sym_t;

    sym_t exp_q[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   or_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a beat yields (eop ? 4-empty : 4) bytes, MSB first, sop on the first, eop on the last.
    function automatic void model_push(input logic [31:0] data, input logic sop,
                                       input logic eop, input logic [1:0] empty);
        int n;
        sym_t s;
        n = eop ? 4 - int'(empty) : 4;
        for (int k = 0; k < n; k++) begin
            s.d = 8'((data >> (8 * (3 - k))) & 32'hFF);
            s.s = sop && (k == 0);
            s.e = eop && (k == n - 1);
            exp_q.push_back(s);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_s;
    logic       prev_e;
    sym_t       got;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_d));
                chk("stall_sop", int'(out_startofpacket), int'(prev_s));
                chk("stall_eop", int'(out_endofpacket), int'(prev_e));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_symbol: got %0h expected none (cycle %0d)", out_data, cyc);
                end else begin
                    got = exp_q.pop_front();
                    chk("sym_data", int'(out_data), int'(got.d));
                    chk("sym_sop", int'(out_startofpacket), int'(got.s));
                    chk("sym_eop", int'(out_endofpacket), int'(got.e));
                end
                pop_cyc.push_back(cyc);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_s = out_startofpacket;
            prev_e = out_endofpacket;
        end
    end

    // Called just after a rising edge; returns just after the rising edge that took the beat.
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [1:0] emp, output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_data = d;
        in_startofpacket = s;
        in_endofpacket = e;
        in_empty = emp;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                model_push(d, s, e, emp);
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance of %0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_timing(input string name, input int first, input int n);
        chk({name, "_count"}, pop_cyc.size(), n);
        for (int i = 0; i < n && i < pop_cyc.size(); i++)
            chk({name, "_cycle"}, pop_cyc[i], first + i);
    endtask

    initial begin
        int a0, a1;
        int nb;
        bit ok;

        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sop", int'(out_startofpacket), 0);
        chk("rst_out_eop", int'(out_endofpacket), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single beat, full rate
        pop_cyc.delete();
        send_beat(32'hAABBCCDD, 1'b1, 1'b1, 2'd0, a0);
        drain();
        chk_timing("single", a0 + 1, 4);

        // two-beat packet, second beat trimmed to 2 symbols, no bubble
        pop_cyc.delete();
        send_beat(32'h01020304, 1'b1, 1'b0, 2'd0, a0);
        send_beat(32'h05060708, 1'b0, 1'b1, 2'd2, a1);
        drain();
        chk_timing("multi", a0 + 1, 6);
        chk("multi_reaccept", a1, a0 + 4);

        // same packet under 1,0,0,1 backpressure
        or_mode = 1;
        send_beat(32'h01020304, 1'b1, 1'b0, 2'd0, a0);
        send_beat(32'h05060708, 1'b0, 1'b1, 2'd2, a1);
        drain();
        or_mode = 0;
        @(posedge clk);
        #1;

        // single-symbol packet, next beat taken the cycle it leaves
        pop_cyc.delete();
        send_beat(32'hEE000000, 1'b1, 1'b1, 2'd3, a0);
        send_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0, a1);
        drain();
        chk_timing("empty3", a0 + 1, 5);
        chk("empty3_reaccept", a1, a0 + 1);

        // in_empty on a non-eop beat is ignored
        pop_cyc.delete();
        send_beat(32'h11223344, 1'b1, 1'b0, 2'd2, a0);
        send_beat(32'h55667788, 1'b0, 1'b1, 2'd1, a1);
        drain();
        chk("nonEop_count", pop_cyc.size(), 7);

        // reset while symbol CC is on the output
        pop_cyc.delete();
        send_beat(32'hAABBCCDD, 1'b1, 1'b1, 2'd0, a0);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (pop_cyc.size() >= 2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reach_bb", int'(ok), 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_data", int'(out_data), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pop_cyc.delete();
        send_beat(32'h10203040, 1'b1, 1'b1, 2'd0, a0);
        drain();
        chk_timing("postrst", a0 + 1, 4);

        // random packets with random backpressure and idle gaps
        or_mode = 2;
        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_beat($urandom, b == 0, b == nb - 1, 2'($urandom_range(0, 3)), a0);
            end
        end
        drain();
        or_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
